alu_rsv_station: RTL and testbench

// - Reservation station feeding the 1-cycle ALU: holds renamed ALU ops from dispatch,

---
 rtl/alu_rsv_station_pkg.sv | 32 +++
 rtl/alu_rsv_station_age_select.sv | 40 ++++
 rtl/alu_rsv_station.sv | 112 +++++++++++
 tb/tb_alu_rsv_station.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rsv_station_pkg.sv
// Shared out-of-order types for the ALU reservation station: physical tag widths,
// ALU opcodes and the renamed-op entry record carried from dispatch to issue.
package alu_rsv_station_pkg;

  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_BITS      = 5;
  localparam int XLEN          = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_BITS-1:0]      rob_tag;
    alu_op_e                  alu_op;
    logic                     alu_src;    // 1: second operand is the immediate
    logic [XLEN-1:0]          immediate;
    logic                     reg_write;
  } rs_entry_t;

  // An immediate-form op never waits on prs2.
  function automatic logic entry_ready(input rs_entry_t e);
    return e.prs1_ready && (e.prs2_ready || e.alu_src);
  endfunction

endpackage

// File: rtl/alu_rsv_station_age_select.sv
// Age matrix plus oldest-eligible picker. age_q[i][j]=1 means entry i is younger
// than entry j; the grant is the eligible entry with no older eligible peer.
module rs_age_select #(
  parameter int RS_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RS_SIZE-1:0] valid,
  input  logic [RS_SIZE-1:0] alloc_oh,
  input  logic [RS_SIZE-1:0] eligible,
  output logic [RS_SIZE-1:0] grant_oh
);

  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;

  // A new entry is younger than every currently valid one and older than none.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (alloc_oh[i]) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          age_d[i][j] = valid[j] && (j != i);
          age_d[j][i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < RS_SIZE; i++)
      grant_oh[i] = eligible[i] && !(|(age_q[i] & eligible));
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

endmodule

// File: rtl/alu_rsv_station.sv
// Reservation station for the single-cycle ALU: buffers renamed ops, wakes operands
// from writeback broadcasts, and issues the oldest ready op each cycle.
module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int NUM_WB  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  dispatch_valid,
  input  rs_entry_t                             dispatch_entry,
  output logic                                  dispatch_ready,
  input  logic [NUM_WB-1:0]                     wb_en,
  input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0]  wb_prd,
  input  logic                                  fu_ready,
  output logic                                  issue_en,
  output rs_entry_t                             issue_entry,
  output logic [$clog2(RS_SIZE+1)-1:0]          occupancy,
  input  logic                                  flush
);

  localparam int OCC_W = $clog2(RS_SIZE+1);

  logic [RS_SIZE-1:0] valid_q, valid_d;
  rs_entry_t          entry_q [RS_SIZE];
  rs_entry_t          entry_d [RS_SIZE];
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [RS_SIZE-1:0] free_oh, alloc_oh, eligible, grant_oh, issue_oh;
  logic               dispatch_fire;
  rs_entry_t          disp_entry;

  function automatic logic wb_hit(input logic [PHYS_REG_BITS-1:0] tag,
                                  input logic [NUM_WB-1:0] en,
                                  input logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++)
      if (en[p] && prd[p] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Lowest clear bit of valid_q.
  assign free_oh        = ~valid_q & (valid_q + RS_SIZE'(1));
  assign dispatch_ready = |free_oh;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign alloc_oh       = dispatch_fire ? free_oh : '0;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < RS_SIZE; i++)
      eligible[i] = valid_q[i] && entry_ready(entry_q[i]);
  end

  rs_age_select #(.RS_SIZE(RS_SIZE)) u_age (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid_q),
    .alloc_oh (alloc_oh),
    .eligible (eligible),
    .grant_oh (grant_oh)
  );

  assign issue_en  = fu_ready && |eligible;
  assign issue_oh  = issue_en ? grant_oh : '0;
  assign occupancy = occ_q;

  always_comb begin
    issue_entry = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (grant_oh[i]) issue_entry = entry_q[i];
  end

  // Operands produced in the dispatch cycle are captured as already ready.
  always_comb begin
    disp_entry = dispatch_entry;
    if (wb_hit(dispatch_entry.prs1, wb_en, wb_prd)) disp_entry.prs1_ready = 1'b1;
    if (wb_hit(dispatch_entry.prs2, wb_en, wb_prd)) disp_entry.prs2_ready = 1'b1;
  end

  always_comb begin
    valid_d = (valid_q & ~issue_oh) | alloc_oh;
    occ_d   = occ_q + OCC_W'(dispatch_fire) - OCC_W'(issue_en);
    for (int i = 0; i < RS_SIZE; i++) begin
      entry_d[i] = entry_q[i];
      if (wb_hit(entry_q[i].prs1, wb_en, wb_prd)) entry_d[i].prs1_ready = 1'b1;
      if (wb_hit(entry_q[i].prs2, wb_en, wb_prd)) entry_d[i].prs2_ready = 1'b1;
      if (alloc_oh[i]) entry_d[i] = disp_entry;
    end
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= entry_d[i];
  end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station: an in-order list model (dispatch order = age)
// is compared every cycle, with hand-computed literal checks at key points.
module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;

  localparam int RS = 4;
  localparam int NW = 2;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            dispatch_valid;
  rs_entry_t                       dispatch_entry;
  logic                            dispatch_ready;
  logic [NW-1:0]                   wb_en;
  logic [NW-1:0][PHYS_REG_BITS-1:0] wb_prd;
  logic                            fu_ready;
  logic                            issue_en;
  rs_entry_t                       issue_entry;
  logic [$clog2(RS+1)-1:0]         occupancy;
  logic                            flush;

  int tests = 0;
  int fails = 0;

  alu_rsv_station #(.RS_SIZE(RS), .NUM_WB(NW)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .dispatch_ready (dispatch_ready),
    .wb_en          (wb_en),
    .wb_prd         (wb_prd),
    .fu_ready       (fu_ready),
    .issue_en       (issue_en),
    .issue_entry    (issue_entry),
    .occupancy      (occupancy),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue in dispatch order, so the oldest ready op is the first ready one.
  rs_entry_t mq[$];
  int        m_idx;
  bit        m_issue;
  bit        m_can_disp;
  rs_entry_t m_tmp;

  function automatic bit rdy(input rs_entry_t e);
    return e.prs1_ready && (e.alu_src || e.prs2_ready);
  endfunction

  function automatic bit woke(input logic [PHYS_REG_BITS-1:0] t);
    for (int p = 0; p < NW; p++)
      if (wb_en[p] && wb_prd[p] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    m_idx = -1;
    for (int k = 0; k < mq.size(); k++)
      if (m_idx < 0 && rdy(mq[k])) m_idx = k;
    m_issue = fu_ready && (m_idx >= 0);
    if (!rst) begin
      chk("m_issue_en", 128'(issue_en), 128'(m_issue));
      chk("m_occupancy", 128'(occupancy), 128'(mq.size()));
      chk("m_dispatch_ready", 128'(dispatch_ready), 128'(mq.size() < RS));
      if (m_issue) chk("m_issue_entry", 128'(issue_entry), 128'(mq[m_idx]));
    end
    if (rst || flush) mq.delete();
    else begin
      m_can_disp = mq.size() < RS;
      if (m_issue) mq.delete(m_idx);
      for (int k = 0; k < mq.size(); k++) begin
        m_tmp = mq[k];
        if (woke(m_tmp.prs1)) m_tmp.prs1_ready = 1'b1;
        if (woke(m_tmp.prs2)) m_tmp.prs2_ready = 1'b1;
        mq[k] = m_tmp;
      end
      if (dispatch_valid && m_can_disp) begin
        m_tmp = dispatch_entry;
        if (woke(m_tmp.prs1)) m_tmp.prs1_ready = 1'b1;
        if (woke(m_tmp.prs2)) m_tmp.prs2_ready = 1'b1;
        mq.push_back(m_tmp);
      end
    end
  end

  function automatic rs_entry_t mk(input int prd, input int rob, input int p1, input bit r1,
                                   input int p2, input bit r2, input bit src);
    rs_entry_t e;
    e.prs1       = PHYS_REG_BITS'(p1);
    e.prs2       = PHYS_REG_BITS'(p2);
    e.prs1_ready = r1;
    e.prs2_ready = r2;
    e.prd        = PHYS_REG_BITS'(prd);
    e.rob_tag    = ROB_BITS'(rob);
    e.alu_op     = ALU_ADD;
    e.alu_src    = src;
    e.immediate  = XLEN'(rob * 16);
    e.reg_write  = 1'b1;
    return e;
  endfunction

  // Advance to the next cycle and apply that cycle's inputs.
  task automatic cyc(input bit dv, input rs_entry_t e, input logic [NW-1:0] we,
                     input int p0, input int p1, input bit fl);
    @(posedge clk); #1;
    dispatch_valid = dv;
    dispatch_entry = e;
    wb_en          = we;
    wb_prd[0]      = PHYS_REG_BITS'(p0);
    wb_prd[1]      = PHYS_REG_BITS'(p1);
    flush          = fl;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; fu_ready = 1'b1; flush = 1'b0;
    dispatch_valid = 1'b0; dispatch_entry = '0; wb_en = '0; wb_prd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_issue_en", 128'(issue_en), 128'd0);
    chk("rst_occupancy", 128'(occupancy), 128'd0);
    chk("rst_dispatch_ready", 128'(dispatch_ready), 128'd1);

    // p5 = p1 + p2, both ready
    cyc(1'b1, mk(5, 3, 1, 1'b1, 2, 1'b1, 1'b0), '0, 0, 0, 1'b0);
    @(negedge clk); chk("add_occ_before", 128'(occupancy), 128'd0);
    idle();
    @(negedge clk);
    chk("add_issue_en", 128'(issue_en), 128'd1);
    chk("add_prd", 128'(issue_entry.prd), 128'd5);
    chk("add_rob", 128'(issue_entry.rob_tag), 128'd3);
    chk("add_occ", 128'(occupancy), 128'd1);
    idle();
    @(negedge clk); chk("add_occ_after", 128'(occupancy), 128'd0);

    // prs1=p7 waits for wakeup on port 1 three cycles later
    cyc(1'b1, mk(10, 4, 7, 1'b0, 2, 1'b1, 1'b0), '0, 0, 0, 1'b0);
    idle();
    @(negedge clk); chk("wake_c1_no_issue", 128'(issue_en), 128'd0);
    idle();
    @(negedge clk); chk("wake_c2_no_issue", 128'(issue_en), 128'd0);
    cyc(1'b0, '0, 2'b10, 0, 7, 1'b0);
    @(negedge clk); chk("wake_c3_no_issue", 128'(issue_en), 128'd0);
    idle();
    @(negedge clk);
    chk("wake_c4_issue", 128'(issue_en), 128'd1);
    chk("wake_c4_rob", 128'(issue_entry.rob_tag), 128'd4);

    // fill with immediate-form ops waiting on p20..p23
    for (int k = 0; k < RS; k++)
      cyc(1'b1, mk(40 + k, 10 + k, 20 + k, 1'b0, 0, 1'b0, 1'b1), '0, 0, 0, 1'b0);
    cyc(1'b1, mk(44, 14, 1, 1'b1, 0, 1'b0, 1'b1), '0, 0, 0, 1'b0);
    @(negedge clk);
    chk("full_dispatch_ready", 128'(dispatch_ready), 128'd0);
    chk("full_occ", 128'(occupancy), 128'd4);
    cyc(1'b0, '0, 2'b11, 23, 20, 1'b0);
    @(negedge clk); chk("full_wake_no_issue", 128'(issue_en), 128'd0);
    idle();
    @(negedge clk); chk("oldest_first_rob", 128'(issue_entry.rob_tag), 128'd10);
    idle();
    @(negedge clk);
    chk("newest_next_rob", 128'(issue_entry.rob_tag), 128'd13);
    chk("newest_next_occ", 128'(occupancy), 128'd3);
    cyc(1'b0, '0, 2'b01, 21, 0, 1'b0);
    @(negedge clk); chk("mid_no_issue", 128'(issue_en), 128'd0);
    cyc(1'b0, '0, 2'b01, 22, 0, 1'b0);
    @(negedge clk); chk("mid_rob11", 128'(issue_entry.rob_tag), 128'd11);
    idle();
    @(negedge clk); chk("mid_rob12", 128'(issue_entry.rob_tag), 128'd12);
    idle();
    @(negedge clk); chk("drained_occ", 128'(occupancy), 128'd0);

    // prs2=p9 produced in the dispatch cycle, then dispatch alongside issue
    cyc(1'b1, mk(11, 20, 1, 1'b1, 9, 1'b0, 1'b0), 2'b01, 9, 0, 1'b0);
    cyc(1'b1, mk(12, 21, 1, 1'b1, 2, 1'b1, 1'b0), '0, 0, 0, 1'b0);
    @(negedge clk);
    chk("bypass_issue_rob", 128'(issue_entry.rob_tag), 128'd20);
    chk("bypass_occ", 128'(occupancy), 128'd1);
    idle();
    @(negedge clk);
    chk("dual_issue_rob", 128'(issue_entry.rob_tag), 128'd21);
    chk("dual_occ_same", 128'(occupancy), 128'd1);

    // fu_ready low holds a ready op
    cyc(1'b1, mk(13, 22, 1, 1'b1, 2, 1'b1, 1'b0), '0, 0, 0, 1'b0);
    idle(); fu_ready = 1'b0;
    @(negedge clk); chk("fu_busy_no_issue", 128'(issue_en), 128'd0);
    idle(); fu_ready = 1'b1;
    @(negedge clk); chk("fu_free_rob", 128'(issue_entry.rob_tag), 128'd22);

    // flush with three entries waiting and a dispatch offered
    for (int k = 0; k < 3; k++)
      cyc(1'b1, mk(50 + k, 23 + k, 30 + k, 1'b0, 0, 1'b0, 1'b1), '0, 0, 0, 1'b0);
    cyc(1'b1, mk(53, 26, 1, 1'b1, 2, 1'b1, 1'b0), '0, 0, 0, 1'b1);
    @(negedge clk); chk("flush_occ_before", 128'(occupancy), 128'd3);
    idle();
    @(negedge clk);
    chk("flush_occ", 128'(occupancy), 128'd0);
    chk("flush_issue_en", 128'(issue_en), 128'd0);
    chk("flush_dispatch_ready", 128'(dispatch_ready), 128'd1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
